// File: rtl/xtensa_rst_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xtensa_rst_seq_pkg : shared state encoding and default constants
// Rev 1.0
// ----------------------------------------------------------------------------
package xtensa_rst_seq_pkg;

  localparam int DEF_NUM_CORES      = 2;
  localparam int DEF_HOLD_CYCLES    = 100;
  localparam int DEF_STAGGER_CYCLES = 16;
  localparam int DEF_CNT_W          = 16;

  typedef enum logic [2:0] {
    ST_HOLD       = 3'd0,
    ST_STAGGER    = 3'd1,
    ST_STALL_WAIT = 3'd2,
    ST_RUN        = 3'd3,
    ST_CORE_HOLD  = 3'd4,
    ST_CORE_STALL = 3'd5
  } seq_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xtensa_reset_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xtensa_reset_sequencer_if : request handshake and per-core reset outputs
// Rev 1.0
// ----------------------------------------------------------------------------
interface xtensa_reset_sequencer_if
  import xtensa_rst_seq_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES
);
  localparam int IDX_W = idx_w(NUM_CORES);

  logic                 req_valid;
  logic [IDX_W-1:0]     req_core;
  logic                 req_ready;
  logic                 req_err;
  logic [NUM_CORES-1:0] core_BReset;
  logic [NUM_CORES-1:0] core_RunStall;
  logic                 busy;
  logic                 done_pulse;

  modport master (
    output req_valid, req_core,
    input  req_ready, req_err, core_BReset, core_RunStall, busy, done_pulse
  );

  modport slave (
    input  req_valid, req_core,
    output req_ready, req_err, core_BReset, core_RunStall, busy, done_pulse
  );
endinterface
`default_nettype wire

// File: rtl/rst_seq_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rst_seq_timer : restartable saturating up-counter
// Rev 1.0
// ----------------------------------------------------------------------------
module rst_seq_timer #(
  parameter int CNT_W = 16
) (
  input  wire logic             CLK,
  input  wire logic             BReset,
  input  wire logic             clear,
  input  wire logic             enable,
  output logic      [CNT_W-1:0] count
);

  // Saturates at all-ones instead of wrapping back to zero.
  always_ff @(posedge CLK or posedge BReset) begin
    if (BReset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/xtensa_reset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// xtensa_reset_sequencer : staggered multi-core reset release and re-reset
// Rev 1.0
// ----------------------------------------------------------------------------
module xtensa_reset_sequencer
  import xtensa_rst_seq_pkg::*;
#(
  parameter int NUM_CORES      = DEF_NUM_CORES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input wire logic                CLK,
  input wire logic                BReset,
  xtensa_reset_sequencer_if.slave bus
);

  localparam int               IDX_W     = idx_w(NUM_CORES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

  seq_state_t           state, state_nx;
  logic [NUM_CORES-1:0] brst, brst_nx;
  logic [NUM_CORES-1:0] stall, stall_nx;
  logic [IDX_W-1:0]     tgt, tgt_nx;
  logic [IDX_W-1:0]     rel, rel_nx;
  logic                 err, err_nx;
  logic                 done, done_nx;
  logic                 tmr_clear;
  logic [CNT_W-1:0]     count;

  rst_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK    (CLK),
    .BReset (BReset),
    .clear  (tmr_clear),
    .enable (state != ST_RUN),
    .count  (count)
  );

  always_comb begin
    state_nx  = state;
    brst_nx   = brst;
    stall_nx  = stall;
    tgt_nx    = tgt;
    rel_nx    = rel;
    err_nx    = 1'b0;
    done_nx   = 1'b0;
    tmr_clear = 1'b0;
    unique case (state)
      ST_HOLD: begin
        if (count == HOLD_LAST) begin
          brst_nx[0] = 1'b0;
          rel_nx     = IDX_W'(1);
          tmr_clear  = 1'b1;
          // A single core has nothing to stagger, so go straight to the stall wait.
          state_nx   = (NUM_CORES == 1) ? ST_STALL_WAIT : ST_STAGGER;
        end
      end
      ST_STAGGER: begin
        if (count == STAG_LAST) begin
          brst_nx[rel] = 1'b0;
          rel_nx       = rel + IDX_W'(1);
          tmr_clear    = 1'b1;
          if (int'(rel) == NUM_CORES - 1) begin
            state_nx = ST_STALL_WAIT;
          end
        end
      end
      ST_STALL_WAIT: begin
        if (count == STAG_LAST) begin
          stall_nx  = '0;
          done_nx   = 1'b1;
          tmr_clear = 1'b1;
          state_nx  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.req_valid) begin
          if (int'(bus.req_core) < NUM_CORES) begin
            brst_nx[bus.req_core]  = 1'b1;
            stall_nx[bus.req_core] = 1'b1;
            tgt_nx                 = bus.req_core;
            tmr_clear              = 1'b1;
            state_nx               = ST_CORE_HOLD;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      ST_CORE_HOLD: begin
        if (count == HOLD_LAST) begin
          brst_nx[tgt] = 1'b0;
          tmr_clear    = 1'b1;
          state_nx     = ST_CORE_STALL;
        end
      end
      ST_CORE_STALL: begin
        if (count == STAG_LAST) begin
          stall_nx[tgt] = 1'b0;
          done_nx       = 1'b1;
          tmr_clear     = 1'b1;
          state_nx      = ST_RUN;
        end
      end
      default: begin
        state_nx = ST_HOLD;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge BReset) begin
    if (BReset) begin
      state <= ST_HOLD;
      brst  <= '1;
      stall <= '1;
      tgt   <= '0;
      rel   <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      brst  <= brst_nx;
      stall <= stall_nx;
      tgt   <= tgt_nx;
      rel   <= rel_nx;
      err   <= err_nx;
      done  <= done_nx;
    end
  end

  assign bus.req_ready     = (state == ST_RUN);
  assign bus.busy          = (state != ST_RUN);
  assign bus.req_err       = err;
  assign bus.done_pulse    = done;
  assign bus.core_BReset   = brst;
  assign bus.core_RunStall = stall;

endmodule
`default_nettype wire

// File: tb/tb_xtensa_reset_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_xtensa_reset_sequencer : three configurations against a timing model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_xtensa_reset_sequencer;

  logic CLK = 1'b0;
  logic BReset = 1'b1;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Instance parameters: a = defaults, b = 3 cores, c = single core.
  int P_N[3] = '{2, 3, 1};
  int P_H[3] = '{100, 6, 5};
  int P_S[3] = '{16, 4, 3};

  logic       rv[3];
  logic [2:0] rc[3];

  xtensa_reset_sequencer_if #(.NUM_CORES(2)) bus_a ();
  xtensa_reset_sequencer_if #(.NUM_CORES(3)) bus_b ();
  xtensa_reset_sequencer_if #(.NUM_CORES(1)) bus_c ();

  assign bus_a.req_valid = rv[0];
  assign bus_b.req_valid = rv[1];
  assign bus_c.req_valid = rv[2];
  assign bus_a.req_core  = rc[0][0:0];
  assign bus_b.req_core  = rc[1][1:0];
  assign bus_c.req_core  = rc[2][0:0];

  xtensa_reset_sequencer dut_a (.CLK(CLK), .BReset(BReset), .bus(bus_a));
  xtensa_reset_sequencer #(.NUM_CORES(3), .HOLD_CYCLES(6), .STAGGER_CYCLES(4), .CNT_W(8))
    dut_b (.CLK(CLK), .BReset(BReset), .bus(bus_b));
  xtensa_reset_sequencer #(.NUM_CORES(1), .HOLD_CYCLES(5), .STAGGER_CYCLES(3), .CNT_W(4))
    dut_c (.CLK(CLK), .BReset(BReset), .bus(bus_c));

  logic [7:0] o_brst[3], o_stall[3];
  logic       o_ready[3], o_err[3], o_busy[3], o_done[3];

  assign o_brst[0]  = 8'(bus_a.core_BReset);
  assign o_brst[1]  = 8'(bus_b.core_BReset);
  assign o_brst[2]  = 8'(bus_c.core_BReset);
  assign o_stall[0] = 8'(bus_a.core_RunStall);
  assign o_stall[1] = 8'(bus_b.core_RunStall);
  assign o_stall[2] = 8'(bus_c.core_RunStall);
  assign o_ready[0] = bus_a.req_ready;
  assign o_ready[1] = bus_b.req_ready;
  assign o_ready[2] = bus_c.req_ready;
  assign o_err[0]   = bus_a.req_err;
  assign o_err[1]   = bus_b.req_err;
  assign o_err[2]   = bus_c.req_err;
  assign o_busy[0]  = bus_a.busy;
  assign o_busy[1]  = bus_b.busy;
  assign o_busy[2]  = bus_c.busy;
  assign o_done[0]  = bus_a.done_pulse;
  assign o_done[1]  = bus_b.done_pulse;
  assign o_done[2]  = bus_c.done_pulse;

  task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst=%0d t=%0t actual=%0h expected=%0h", nm, k, $time, act, exp);
    end
  endtask

  // Model: elapsed edges since the last reference point (reset release or accepted request).
  bit m_cseq[3];
  int m_el[3];
  int m_tgt[3];
  bit m_err[3];

  function automatic bit m_running(input int k);
    if (m_cseq[k]) return m_el[k] >= P_H[k] + P_S[k];
    return m_el[k] >= P_H[k] + P_N[k] * P_S[k];
  endfunction

  function automatic int req_idx(input int k);
    if (k == 1) return int'(rc[1][1:0]);
    return int'(rc[k][0]);
  endfunction

  always @(posedge CLK or posedge BReset) begin
    for (int k = 0; k < 3; k++) begin
      if (BReset) begin
        m_cseq[k] = 1'b0;
        m_el[k]   = 0;
        m_err[k]  = 1'b0;
      end else begin
        bit run;
        run      = m_running(k);
        m_err[k] = 1'b0;
        if (run && rv[k] && (req_idx(k) < P_N[k])) begin
          m_cseq[k] = 1'b1;
          m_tgt[k]  = req_idx(k);
          m_el[k]   = 0;
        end else begin
          if (run && rv[k]) m_err[k] = 1'b1;
          m_el[k]++;
        end
      end
    end
  end

  always @(negedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      logic [7:0] eb, es;
      bit         ed;
      eb = '0;
      es = '0;
      if (m_cseq[k]) begin
        eb[m_tgt[k]] = (m_el[k] < P_H[k]);
        es[m_tgt[k]] = (m_el[k] < P_H[k] + P_S[k]);
        ed = (m_el[k] == P_H[k] + P_S[k]);
      end else begin
        for (int i = 0; i < P_N[k]; i++) begin
          eb[i] = (m_el[k] < P_H[k] + i * P_S[k]);
          es[i] = (m_el[k] < P_H[k] + P_N[k] * P_S[k]);
        end
        ed = (m_el[k] == P_H[k] + P_N[k] * P_S[k]);
      end
      cmp("model_core_BReset",   k, 32'(o_brst[k]),  32'(eb));
      cmp("model_core_RunStall", k, 32'(o_stall[k]), 32'(es));
      cmp("model_done_pulse",    k, 32'(o_done[k]),  32'(ed));
      cmp("model_req_ready",     k, 32'(o_ready[k]), 32'(m_running(k)));
      cmp("model_busy",          k, 32'(o_busy[k]),  32'(!m_running(k)));
      cmp("model_req_err",       k, 32'(o_err[k]),   32'(m_err[k]));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rv[k] = 1'b0;
      rc[k] = '0;
    end
    BReset = 1'b1;
    edges(3);
    cmp("rst_brst_a",  0, 32'(o_brst[0]),  32'h3);
    cmp("rst_stall_a", 0, 32'(o_stall[0]), 32'h3);
    cmp("rst_ready_a", 0, 32'(o_ready[0]), 32'h0);
    cmp("rst_busy_a",  0, 32'(o_busy[0]),  32'h1);
    cmp("rst_brst_b",  1, 32'(o_brst[1]),  32'h7);

    // Power-up with a request held on instance a throughout.
    BReset = 1'b0;
    rv[0] = 1'b1;
    rc[0] = 3'd1;
    edges(99);
    cmp("pu_e99_brst_a",  0, 32'(o_brst[0]),  32'h3);
    edges(1);
    cmp("pu_e100_brst_a", 0, 32'(o_brst[0]),  32'h2);
    edges(16);
    cmp("pu_e116_brst_a", 0, 32'(o_brst[0]),  32'h0);
    edges(15);
    cmp("pu_e131_stall_a", 0, 32'(o_stall[0]), 32'h3);
    cmp("pu_e131_ready_a", 0, 32'(o_ready[0]), 32'h0);
    edges(1);
    cmp("pu_e132_stall_a", 0, 32'(o_stall[0]), 32'h0);
    cmp("pu_e132_done_a",  0, 32'(o_done[0]),  32'h1);
    cmp("pu_e132_ready_a", 0, 32'(o_ready[0]), 32'h1);
    cmp("pu_e132_busy_a",  0, 32'(o_busy[0]),  32'h0);
    rv[0] = 1'b0;
    edges(1);
    cmp("pu_e133_done_a",  0, 32'(o_done[0]),  32'h0);

    // Out-of-range request on b, in-range request on c.
    rv[1] = 1'b1; rc[1] = 3'd3;
    rv[2] = 1'b1; rc[2] = 3'd0;
    edges(1);
    rv[1] = 1'b0;
    rv[2] = 1'b0;
    cmp("oor_err_b",   1, 32'(o_err[1]),   32'h1);
    cmp("oor_brst_b",  1, 32'(o_brst[1]),  32'h0);
    cmp("oor_busy_b",  1, 32'(o_busy[1]),  32'h0);
    cmp("creq_brst_c", 2, 32'(o_brst[2]),  32'h1);
    edges(1);
    cmp("oor_err_clr_b", 1, 32'(o_err[1]), 32'h0);

    // Re-reset core 1 of a; a request for core 0 stays asserted while busy.
    rv[0] = 1'b1; rc[0] = 3'd1;
    rv[1] = 1'b1; rc[1] = 3'd2;
    edges(1);
    rv[1] = 1'b0;
    rc[0] = 3'd0;
    cmp("cr_acc_brst_a",  0, 32'(o_brst[0]),  32'h2);
    cmp("cr_acc_stall_a", 0, 32'(o_stall[0]), 32'h2);
    cmp("cr_acc_busy_a",  0, 32'(o_busy[0]),  32'h1);
    edges(99);
    rv[0] = 1'b0;
    cmp("cr_h99_brst_a",  0, 32'(o_brst[0]),  32'h2);
    edges(1);
    cmp("cr_h100_brst_a", 0, 32'(o_brst[0]),  32'h0);
    cmp("cr_h100_stall_a", 0, 32'(o_stall[0]), 32'h2);
    edges(16);
    cmp("cr_s16_stall_a", 0, 32'(o_stall[0]), 32'h0);
    cmp("cr_s16_done_a",  0, 32'(o_done[0]),  32'h1);

    // Abort a core sequence with BReset part-way through CORE_HOLD.
    edges(2);
    rv[0] = 1'b1; rc[0] = 3'd1;
    edges(1);
    rv[0] = 1'b0;
    edges(50);
    BReset = 1'b1;
    #1;
    cmp("abort_brst_a",  0, 32'(o_brst[0]),  32'h3);
    cmp("abort_stall_a", 0, 32'(o_stall[0]), 32'h3);
    cmp("abort_ready_a", 0, 32'(o_ready[0]), 32'h0);
    cmp("abort_stall_b", 1, 32'(o_stall[1]), 32'h7);
    edges(2);
    BReset = 1'b0;
    edges(100);
    cmp("re_e100_brst_a", 0, 32'(o_brst[0]),  32'h2);
    edges(16);
    cmp("re_e116_brst_a", 0, 32'(o_brst[0]),  32'h0);
    edges(16);
    cmp("re_e132_stall_a", 0, 32'(o_stall[0]), 32'h0);
    cmp("re_e132_done_a",  0, 32'(o_done[0]),  32'h1);
    edges(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xtensa_reset_sequencer.md
XTENSA_RESET_SEQUENCER -- requirements
Module: xtensa_reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2: number of sequenced cores, range 1..8.
REQ-002 SHALL have parameter HOLD_CYCLES, default 100: CLK edges a core reset is held, at least 1.
REQ-003 SHALL have parameter STAGGER_CYCLES, default 16: CLK edges between successive releases, at least 1.
REQ-004 SHALL have parameter CNT_W, default 16: timer width; HOLD_CYCLES and NUM_CORES*STAGGER_CYCLES SHALL fit in CNT_W.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-007 BReset  input  1  system reset, asynchronous assert, active-high.
REQ-008 req_valid  input  1  software request to re-reset one core.
REQ-009 req_core  input  max(1,$clog2(NUM_CORES))  index of the core to re-reset.
REQ-010 req_ready  output  1  request accepted on this edge when high together with req_valid.
REQ-011 req_err  output  1  one-cycle pulse: accepted request carried an out-of-range index.
REQ-012 core_BReset  output  NUM_CORES  per-core reset, active-high.
REQ-013 core_RunStall  output  NUM_CORES  per-core RunStall, active-high.
REQ-014 busy  output  1  high in every state except RUN.
REQ-015 done_pulse  output  1  one-cycle pulse when a sequence completes.

Function
REQ-016 SHALL implement states HOLD, STAGGER, STALL_WAIT, RUN, CORE_HOLD and CORE_STALL.
REQ-017 Power-up sequence, counting edges from 1 after BReset deasserts: core_BReset[i] SHALL clear on edge HOLD_CYCLES + i*STAGGER_CYCLES.
REQ-018 All core_RunStall bits SHALL clear together on edge HOLD_CYCLES + NUM_CORES*STAGGER_CYCLES; on that same edge the FSM SHALL enter RUN and assert done_pulse for one cycle.
REQ-019 State flow: HOLD -> STAGGER on release of core 0; STAGGER -> STALL_WAIT on release of the last core; STALL_WAIT -> RUN.
REQ-020 req_ready SHALL be high only in RUN; it SHALL be combinational from state only, with no dependency on req_valid.
REQ-021 An accepted in-range request SHALL set core_BReset[req_core] and core_RunStall[req_core] on the accepting edge and enter CORE_HOLD; other cores SHALL be unaffected.
REQ-022 CORE_HOLD SHALL clear that core's core_BReset HOLD_CYCLES edges after acceptance and enter CORE_STALL.
REQ-023 CORE_STALL SHALL clear that core's core_RunStall STAGGER_CYCLES edges later, return to RUN and pulse done_pulse.
REQ-024 An accepted out-of-range request (req_core >= NUM_CORES) SHALL pulse req_err on the next cycle, stay in RUN and change no core output.
REQ-025 req_valid outside RUN SHALL be ignored, neither queued nor flagged.
REQ-026 The timer SHALL restart from 0 on every state transition and SHALL never wrap.
REQ-027 With NUM_CORES=1, STAGGER SHALL be passed through in zero extra edges, so RunStall clears on edge HOLD_CYCLES+STAGGER_CYCLES.

Reset
REQ-028 BReset high SHALL immediately, asynchronously, set state HOLD, timer 0, core_BReset all ones, core_RunStall all ones, req_ready 0, req_err 0, done_pulse 0 and busy 1.
REQ-029 BReset asserted mid-sequence, including in CORE_HOLD or CORE_STALL, SHALL abort that sequence; the full power-up sequence SHALL restart after deassertion.

Structure
REQ-030 The state enum and the default parameter constants SHALL live in package xtensa_rst_seq_pkg.
REQ-031 The CNT_W-bit restartable up-counter SHALL be the single sub-module rst_seq_timer, with inputs clear and enable and output count.

Verification
REQ-032 Defaults, release BReset -> core_BReset[0] clears on edge 100, core_BReset[1] on edge 116, both RunStall bits on edge 132, done_pulse high exactly one cycle, busy 0 afterwards.
REQ-033 In RUN, req_valid=1, req_core=1 for one cycle -> core_BReset[1] and core_RunStall[1] set on the accepting edge; core_BReset[1] clears 100 edges later; core_RunStall[1] clears 16 edges after that; done_pulse fires; core 0 outputs stay 0 throughout.
REQ-034 NUM_CORES=3, req_core=3 accepted in RUN -> req_err pulse for one cycle, no core output changes, busy stays 0.
REQ-035 req_valid held high from edge 1 to 131 -> req_ready stays 0 throughout; no extra sequence starts; req_ready rises on edge 132.
REQ-036 BReset pulsed at edge 50 of CORE_HOLD for core 1 -> all core_BReset and core_RunStall bits are 1 immediately; after deassertion, timing repeats as in REQ-032.
